// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared widths and frame state encoding for the SPI slave.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int unsigned c_datawidth = 8;
    localparam int unsigned c_addrwidth = c_datawidth - 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_CMD   = 3'd1,
        ST_RD_LOAD   = 3'd2,
        ST_RD_SEND   = 3'd3,
        ST_WR_GET    = 3'd4,
        ST_WR_COMMIT = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_reg_sipo_piso.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_sipo_piso
// Description : MSB-first shift register with serial-in and parallel-load.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_sipo_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             adv,
    input  logic             sin,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Parallel load takes precedence over a shift in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= din;
        end else if (adv) begin
            r_q <= {r_q[WIDTH-2:0], sin};
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/spi_frame_fsm.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_fsm
// Description : SPI slave frame controller: command decode, register read/write.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_fsm
    import spi_pkg::*;
#(
    parameter int DATAWIDTH = c_datawidth,
    parameter int ADDRWIDTH = c_addrwidth
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs_n,
    input  logic                 mosi,
    input  logic                 sclk_rise,
    input  logic                 sclk_fall,
    input  logic [DATAWIDTH-1:0] rdata,
    output logic [ADDRWIDTH-1:0] addr,
    output logic [DATAWIDTH-1:0] wdata,
    output logic                 wr_en,
    output logic                 rd_req,
    output logic                 miso,
    output logic                 miso_oe
);

    localparam int c_cntw = $clog2(DATAWIDTH) + 1;
    localparam logic [c_cntw-1:0] c_cnt_last = c_cntw'(DATAWIDTH - 1);
    localparam logic [c_cntw-1:0] c_cnt_one  = c_cntw'(1);

    state_t                r_state;
    logic [c_cntw-1:0]     r_cnt;
    logic [ADDRWIDTH-1:0]  r_addr;
    logic [DATAWIDTH-1:0]  r_wdata;
    logic                  r_wr_en;
    logic                  r_rd_req;
    logic                  r_rd_phase;
    logic                  r_miso;
    logic                  r_miso_oe;

    logic [DATAWIDTH-1:0]  w_rx_q;
    logic [DATAWIDTH-1:0]  w_tx_q;
    logic                  w_rx_adv;
    logic                  w_tx_load;
    logic                  w_tx_adv;
    logic                  w_fall_only;

    // A fall coinciding with a rise is dropped; the rise is the one acted on.
    assign w_fall_only = sclk_fall & ~sclk_rise;
    assign w_rx_adv    = sclk_rise & ~cs_n &
                         ((r_state == ST_GET_CMD) || (r_state == ST_WR_GET));
    assign w_tx_load   = ~cs_n & (r_state == ST_RD_LOAD) & r_rd_phase;
    assign w_tx_adv    = ~cs_n & (r_state == ST_RD_SEND) & w_fall_only;

    shift_reg_sipo_piso #(.WIDTH(DATAWIDTH)) u_rx (
        .clk   (clk),
        .reset (reset),
        .load  (1'b0),
        .adv   (w_rx_adv),
        .sin   (mosi),
        .din   ('0),
        .q     (w_rx_q)
    );

    shift_reg_sipo_piso #(.WIDTH(DATAWIDTH)) u_tx (
        .clk   (clk),
        .reset (reset),
        .load  (w_tx_load),
        .adv   (w_tx_adv),
        .sin   (1'b0),
        .din   (rdata),
        .q     (w_tx_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wr_en    <= 1'b0;
            r_rd_req   <= 1'b0;
            r_rd_phase <= 1'b0;
            r_miso     <= 1'b0;
            r_miso_oe  <= 1'b0;
        end else begin
            r_wr_en  <= 1'b0;
            r_rd_req <= 1'b0;
            if ((r_state != ST_IDLE) && cs_n) begin
                // Deselect aborts the frame, including a write on its last bit.
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!cs_n) begin
                            r_state <= ST_GET_CMD;
                            r_cnt   <= '0;
                        end
                    end
                    ST_GET_CMD: begin
                        if (sclk_rise) begin
                            if (r_cnt == c_cnt_last) begin
                                r_addr     <= w_rx_q[ADDRWIDTH-1:0];
                                r_cnt      <= '0;
                                r_rd_phase <= 1'b0;
                                if (mosi) begin
                                    r_state  <= ST_RD_LOAD;
                                    r_rd_req <= 1'b1;
                                end else begin
                                    r_state <= ST_WR_GET;
                                end
                            end else begin
                                r_cnt <= r_cnt + c_cnt_one;
                            end
                        end
                    end
                    ST_RD_LOAD: begin
                        // First cycle issues the request, second captures rdata.
                        if (!r_rd_phase) begin
                            r_rd_phase <= 1'b1;
                        end else begin
                            r_state   <= ST_RD_SEND;
                            r_miso    <= rdata[DATAWIDTH-1];
                            r_miso_oe <= 1'b1;
                        end
                    end
                    ST_RD_SEND: begin
                        if (w_fall_only) begin
                            if (r_cnt == c_cnt_last) begin
                                r_state   <= ST_DONE;
                                r_cnt     <= '0;
                                r_miso    <= 1'b0;
                                r_miso_oe <= 1'b0;
                            end else begin
                                r_cnt  <= r_cnt + c_cnt_one;
                                r_miso <= w_tx_q[DATAWIDTH-2];
                            end
                        end
                    end
                    ST_WR_GET: begin
                        if (sclk_rise) begin
                            if (r_cnt == c_cnt_last) begin
                                r_wdata <= {w_rx_q[DATAWIDTH-2:0], mosi};
                                r_wr_en <= 1'b1;
                                r_cnt   <= '0;
                                r_state <= ST_WR_COMMIT;
                            end else begin
                                r_cnt <= r_cnt + c_cnt_one;
                            end
                        end
                    end
                    ST_WR_COMMIT: r_state <= ST_DONE;
                    ST_DONE:      r_state <= ST_DONE;
                    default:      r_state <= ST_IDLE;
                endcase
            end
        end
    end

    wire w_unused = ^{w_rx_q[DATAWIDTH-1], w_tx_q[DATAWIDTH-1], w_tx_q[DATAWIDTH-3:0]};

    assign addr    = r_addr;
    assign wdata   = r_wdata;
    assign wr_en   = r_wr_en;
    assign rd_req  = r_rd_req;
    assign miso    = r_miso;
    assign miso_oe = r_miso_oe;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_fsm
// Description : Directed self-checking bench for spi_frame_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs_n;
    logic       mosi;
    logic       sclk_rise;
    logic       sclk_fall;
    logic [7:0] rdata = 8'hFF;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       wr_en;
    logic       rd_req;
    logic       miso;
    logic       miso_oe;

    logic [7:0] rd_val = 8'h00;
    int         n_checks = 0;
    int         n_errors = 0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic [6:0] last_wr_addr = '0;
    logic [7:0] last_wr_data = '0;
    logic [6:0] last_rd_addr = '0;
    int         wr0;
    int         rd0;

    always #5 clk = ~clk;

    spi_frame_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .rdata     (rdata),
        .addr      (addr),
        .wdata     (wdata),
        .wr_en     (wr_en),
        .rd_req    (rd_req),
        .miso      (miso),
        .miso_oe   (miso_oe)
    );

    // Memory model answers one cycle after a request; garbage otherwise.
    always @(posedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            last_wr_addr = addr;
            last_wr_data = wdata;
        end
        if (rd_req) begin
            rd_cnt++;
            last_rd_addr = addr;
        end
        rdata <= rd_req ? rd_val : 8'hFF;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic frame_start;
        cs_n = 1'b0;
        tick;
    endtask

    task automatic frame_end;
        cs_n = 1'b1;
        tick;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            sclk_rise = 1'b1; tick; sclk_rise = 1'b0; tick;
            sclk_fall = 1'b1; tick; sclk_fall = 1'b0; tick;
        end
    endtask

    task automatic wait_oe(input string tag);
        int t;
        t = 0;
        while (!miso_oe && t < 10) begin
            tick;
            t++;
        end
        if (!miso_oe) check({tag, "_oe_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp);
        wait_oe(tag);
        check({tag, "_bit7"}, miso, exp[7]);
        for (int k = 6; k >= 0; k--) begin
            sclk_fall = 1'b1; tick; sclk_fall = 1'b0;
            check($sformatf("%s_bit%0d", tag, k), {miso_oe, miso}, {1'b1, exp[k]});
            tick;
        end
        sclk_fall = 1'b1; tick; sclk_fall = 1'b0;
        check({tag, "_oe_off"}, miso_oe, 1'b0);
        tick;
    endtask

    initial begin
        reset = 1'b1; cs_n = 1'b1; mosi = 1'b0; sclk_rise = 1'b0; sclk_fall = 1'b0;
        tick; tick;
        check("rst_outputs", {addr, wdata, wr_en, rd_req, miso, miso_oe}, '0);
        reset = 1'b0;
        tick;

        // Write 0xC3 to 0x2A
        wr0 = wr_cnt;
        frame_start;
        send_bits(8'h54, 8);
        check("wr_oe_cmd", miso_oe, 1'b0);
        send_bits(8'hC3, 8);
        check("wr_pulses", wr_cnt - wr0, 1);
        check("wr_addr", last_wr_addr, 7'h2A);
        check("wr_data", last_wr_data, 8'hC3);
        check("wr_oe", miso_oe, 1'b0);
        frame_end;

        // Read 0x96 from 0x2A
        rd0 = rd_cnt;
        rd_val = 8'h96;
        frame_start;
        send_bits(8'h55, 8);
        read_byte("rd", 8'h96);
        check("rd_pulses", rd_cnt - rd0, 1);
        check("rd_addr", last_rd_addr, 7'h2A);
        frame_end;

        // Abort after 5 data bits, then a clean frame
        wr0 = wr_cnt;
        frame_start;
        send_bits(8'h54, 8);
        send_bits(8'hC3, 5);
        frame_end; tick;
        check("abort_no_wr", wr_cnt - wr0, 0);
        frame_start;
        send_bits(8'h54, 8);
        send_bits(8'h3C, 8);
        check("post_abort_wr", wr_cnt - wr0, 1);
        check("post_abort_data", wdata, 8'h3C);
        frame_end;

        // Deselect on the same cycle as the final write bit
        wr0 = wr_cnt;
        frame_start;
        send_bits(8'h54, 8);
        send_bits(8'hA5, 7);
        mosi = 1'b1; sclk_rise = 1'b1; cs_n = 1'b1;
        tick; sclk_rise = 1'b0; tick; tick;
        check("race_no_wr", wr_cnt - wr0, 0);
        check("race_wdata_held", wdata, 8'h3C);

        // Reset after 3 read bits
        rd_val = 8'h96;
        frame_start;
        send_bits(8'h55, 8);
        wait_oe("rst_rd");
        for (int k = 0; k < 3; k++) begin
            sclk_fall = 1'b1; tick; sclk_fall = 1'b0; tick;
        end
        reset = 1'b1;
        tick;
        check("midrd_rst_oe_miso", {miso_oe, miso}, 2'b00);
        check("midrd_rst_all", {addr, wdata, wr_en, rd_req}, '0);
        reset = 1'b0; cs_n = 1'b1;
        tick;

        // Extra SCLK after a completed write
        wr0 = wr_cnt;
        frame_start;
        send_bits(8'h54, 8);
        send_bits(8'h11, 8);
        send_bits(8'hFF, 4);
        check("extra_sclk_wr", wr_cnt - wr0, 1);
        check("extra_sclk_hold", {addr, wdata, miso_oe}, {7'h2A, 8'h11, 1'b0});
        frame_end;

        // Back-to-back write then read of 0x10
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        frame_start;
        send_bits(8'h20, 8);
        send_bits(8'h5A, 8);
        frame_end;
        rd_val = 8'h5A;
        frame_start;
        send_bits(8'h21, 8);
        read_byte("b2b_rd", 8'h5A);
        check("b2b_wr", {wr_cnt - wr0, 1'b0, last_wr_addr, last_wr_data}, {32'd1, 1'b0, 7'h10, 8'h5A});
        check("b2b_rd_req", {rd_cnt - rd0, 1'b0, last_rd_addr}, {32'd1, 1'b0, 7'h10});
        frame_end;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
